// File: rtl/ttc_pkg.sv
// Shared TTC definitions: opcodes, reboot cause codes, reboot FSM states.
package ttc_pkg;

    localparam int unsigned TC_W  = 8;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned IDX_W = 2;

    localparam logic [TC_W-1:0] OP_REBOOT_ARM  = 8'hA5;
    localparam logic [TC_W-1:0] OP_REBOOT_EXEC = 8'h5A;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_CMD  = 2'b01;
    localparam logic [1:0] CAUSE_WDT  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ARM_KEY,
        ARMED,
        EXEC_KEY,
        FIRE,
        LOCK
    } state_e;

    // Key byte expected at frame position idx (MSB byte first).
    function automatic logic [TC_W-1:0] key_byte(input logic [31:0] key, input logic [IDX_W-1:0] idx);
        case (idx)
            2'd0:    key_byte = key[31:24];
            2'd1:    key_byte = key[23:16];
            2'd2:    key_byte = key[15:8];
            default: key_byte = key[7:0];
        endcase
    endfunction

endpackage

// File: rtl/reboot_req_ctrl_if.sv
// Decoded telecommand byte stream (valid/ready handshake).
interface reboot_req_ctrl_if;
    import ttc_pkg::*;

    logic [TC_W-1:0] tc_data;
    logic            tc_sof;
    logic            tc_valid;
    logic            tc_ready;

    modport master (output tc_data, output tc_sof, output tc_valid, input tc_ready);
    modport slave  (input tc_data, input tc_sof, input tc_valid, output tc_ready);

endinterface

// File: rtl/wdt_counter.sv
// Software-kick watchdog: counts down while enabled, one-cycle expire pulse on reaching zero.
module wdt_counter
    import ttc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             kick,
    input  logic [CNT_W-1:0] reload,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expire_q, expire_d;

    // Kick or disable reloads; otherwise saturating decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || kick) begin
            cnt_d = reload;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        expire_d = (cnt_d == '0) && (cnt_q != '0);
    end

    // Counter and expire pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= reload;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire = expire_q;

endmodule

// File: rtl/reboot_req_ctrl.sv
// Reboot request controller: ARM/EXEC keyed command parser plus watchdog, one timed request pulse then lockout.
module reboot_req_ctrl
    import ttc_pkg::*;
#(
    parameter logic [31:0] KEY         = 32'hC0DEB007,
    parameter int unsigned ARM_TIMEOUT = 50_000_000,
    parameter int unsigned WDT_CYCLES  = 100_000_000,
    parameter int unsigned PULSE_LEN   = 16
) (
    input  logic              clk,
    input  logic              rst,
    reboot_req_ctrl_if.slave  tc,
    input  logic              wdt_en,
    input  logic              wdt_kick,
    output logic              reboot_req,
    output logic [1:0]        reboot_cause,
    output logic              armed,
    output logic              key_err
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] arm_tmr_q, arm_tmr_d;
    logic [CNT_W-1:0] pulse_q, pulse_d;
    logic [1:0]       cause_q, cause_d;
    logic             key_err_q, key_err_d;
    logic             armed_q, armed_d;
    logic             reboot_req_q, reboot_req_d;
    logic             tc_ready_q, tc_ready_d;

    logic             acc_c;
    logic             key_hit_c;
    logic             tmr_zero_c;
    logic             wdt_expire;

    assign acc_c      = tc.tc_valid & tc_ready_q;
    assign key_hit_c  = (tc.tc_data == key_byte(KEY, idx_q));
    assign tmr_zero_c = (arm_tmr_q == '0);

    wdt_counter u_wdt (
        .clk    (clk),
        .rst    (rst),
        .en     (wdt_en),
        .kick   (wdt_kick),
        .reload (CNT_W'(WDT_CYCLES)),
        .expire (wdt_expire)
    );

    // Next-state, counters and registered-output decode.
    always_comb begin
        logic fire_cmd;
        fire_cmd   = 1'b0;
        state_d    = state_q;
        idx_d      = idx_q;
        arm_tmr_d  = tmr_zero_c ? '0 : arm_tmr_q - CNT_W'(1);
        pulse_d    = pulse_q;
        cause_d    = cause_q;
        key_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (acc_c && tc.tc_sof && tc.tc_data == OP_REBOOT_ARM) begin
                    state_d = ARM_KEY;
                    idx_d   = '0;
                end
            end
            ARM_KEY: begin
                if (acc_c) begin
                    if (tc.tc_sof) begin
                        // A new frame restarts parsing; only another ARM keeps us here.
                        idx_d = '0;
                        if (tc.tc_data != OP_REBOOT_ARM) state_d = IDLE;
                    end else if (!key_hit_c) begin
                        state_d   = IDLE;
                        key_err_d = 1'b1;
                    end else if (idx_q == IDX_W'(3)) begin
                        state_d   = ARMED;
                        arm_tmr_d = CNT_W'(ARM_TIMEOUT);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ARMED, EXEC_KEY: begin
                // A fresh ARM always restarts; otherwise timeout beats any byte.
                if (acc_c && tc.tc_sof && tc.tc_data == OP_REBOOT_ARM) begin
                    state_d = ARM_KEY;
                    idx_d   = '0;
                end else if (tmr_zero_c) begin
                    state_d = IDLE;
                end else if (acc_c) begin
                    if (tc.tc_sof) begin
                        idx_d = '0;
                        if (tc.tc_data == OP_REBOOT_EXEC) begin
                            state_d = EXEC_KEY;
                        end else begin
                            state_d   = IDLE;
                            key_err_d = 1'b1;
                        end
                    end else if (state_q == EXEC_KEY) begin
                        if (!key_hit_c) begin
                            state_d   = IDLE;
                            key_err_d = 1'b1;
                        end else if (idx_q == IDX_W'(3)) begin
                            fire_cmd = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            FIRE: begin
                if (pulse_q == '0) begin
                    state_d = LOCK;
                end else begin
                    pulse_d = pulse_q - CNT_W'(1);
                end
            end
            LOCK: begin
            end
            default: state_d = IDLE;
        endcase

        // Command completion wins over a coincident watchdog expiry.
        if (fire_cmd) begin
            state_d = FIRE;
            cause_d = CAUSE_CMD;
            pulse_d = CNT_W'(PULSE_LEN - 1);
        end else if (wdt_expire && state_q != FIRE && state_q != LOCK) begin
            state_d = FIRE;
            cause_d = CAUSE_WDT;
            pulse_d = CNT_W'(PULSE_LEN - 1);
        end

        armed_d      = (state_d == ARMED) || (state_d == EXEC_KEY);
        reboot_req_d = (state_d == FIRE);
        tc_ready_d   = (state_d != FIRE) && (state_d != LOCK);
    end

    // State, counters and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            arm_tmr_q    <= '0;
            pulse_q      <= '0;
            cause_q      <= CAUSE_NONE;
            key_err_q    <= 1'b0;
            armed_q      <= 1'b0;
            reboot_req_q <= 1'b0;
            tc_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            arm_tmr_q    <= arm_tmr_d;
            pulse_q      <= pulse_d;
            cause_q      <= cause_d;
            key_err_q    <= key_err_d;
            armed_q      <= armed_d;
            reboot_req_q <= reboot_req_d;
            tc_ready_q   <= tc_ready_d;
        end
    end

    assign tc.tc_ready   = tc_ready_q;
    assign reboot_req    = reboot_req_q;
    assign reboot_cause  = cause_q;
    assign armed         = armed_q;
    assign key_err       = key_err_q;

endmodule
